// File: rtl/key_move_scheduler.sv
// rtl/key_move_scheduler.sv - keypress decode, per-player move FIFOs, frame-paced round-robin grant
module key_move_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  input  logic [1:0] cmd_ready,
  output logic [1:0] cmd_valid,
  output logic [3:0] cmd_dir,
  output logic [1:0] overflow,
  output logic [7:0] missed_frames,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
  state_t state, state_next;

  logic [7:0]    key_prev;
  logic [1:0]    push, push_ok, pop;
  logic [1:0]    push_dir;
  logic [1:0]    mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] count [2];

  logic          fs1, fs2, fs3, tick;
  logic          first_ptr, pending, cur, nonempty, advance;
  logic [TW-1:0] wait_cnt;

  // A press only counts on the cycle the code differs from last cycle, so held keys never repeat.
  always_comb begin
    push     = 2'b00;
    push_dir = 2'b00;
    if (keycode != key_prev && keycode != 8'h00) begin
      case (keycode)
        8'h1A: begin push = 2'b01; push_dir = 2'b00; end
        8'h16: begin push = 2'b01; push_dir = 2'b01; end
        8'h04: begin push = 2'b01; push_dir = 2'b10; end
        8'h07: begin push = 2'b01; push_dir = 2'b11; end
        8'h52: begin push = 2'b10; push_dir = 2'b00; end
        8'h51: begin push = 2'b10; push_dir = 2'b01; end
        8'h50: begin push = 2'b10; push_dir = 2'b10; end
        8'h4F: begin push = 2'b10; push_dir = 2'b11; end
        default: ;
      endcase
    end
  end

  assign pop = cmd_valid & cmd_ready;

  // A full FIFO still accepts a push when its head is being popped the same cycle.
  always_comb begin
    push_ok = 2'b00;
    for (int n = 0; n < 2; n++)
      push_ok[n] = push[n] && (count[n] != FULL || pop[n]);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      key_prev <= 8'h00;
      overflow <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[n][i] <= 2'b00;
      end
    end else begin
      key_prev <= keycode;
      for (int n = 0; n < 2; n++) begin
        if (push_ok[n]) begin
          mem[n][wr_ptr[n]] <= push_dir;
          wr_ptr[n]         <= wr_ptr[n] + 1'b1;
        end
        if (push[n] && !push_ok[n]) overflow[n] <= 1'b1;
        if (pop[n]) rd_ptr[n] <= rd_ptr[n] + 1'b1;
        if (push_ok[n] && !pop[n])      count[n] <= count[n] + 1'b1;
        else if (!push_ok[n] && pop[n]) count[n] <= count[n] - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fs1 <= 1'b0;
      fs2 <= 1'b0;
      fs3 <= 1'b0;
    end else begin
      fs1 <= frame_clk;
      fs2 <= fs1;
      fs3 <= fs2;
    end
  end

  assign tick = fs2 && !fs3;

  always_comb begin
    cur        = (state == SERVE_B) ? ~first_ptr : first_ptr;
    nonempty   = (count[cur] != '0);
    cmd_valid  = 2'b00;
    cmd_dir    = 4'b0000;
    if (state != IDLE && nonempty) begin
      cmd_valid[cur]              = 1'b1;
      cmd_dir[{cur, 1'b0} +: 2]   = mem[cur][rd_ptr[cur]];
    end
    advance    = (state != IDLE) &&
                 (!nonempty || cmd_ready[cur] || wait_cnt == LAST_WAIT);
    state_next = state;
    case (state)
      IDLE:    if (tick || pending) state_next = SERVE_A;
      SERVE_A: if (advance) state_next = SERVE_B;
      SERVE_B: if (advance) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      first_ptr     <= 1'b0;
      pending       <= 1'b0;
      missed_frames <= 8'h00;
      wait_cnt      <= '0;
    end else begin
      state <= state_next;
      if (state == SERVE_B && advance) first_ptr <= ~first_ptr;
      if (advance || state == IDLE) wait_cnt <= '0;
      else                          wait_cnt <= wait_cnt + 1'b1;
      // One frame can wait behind a busy grant; any further ticks are counted as lost.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (tick) begin
        if (!pending)                    pending       <= 1'b1;
        else if (missed_frames != 8'hFF) missed_frames <= missed_frames + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_key_move_scheduler.sv
// tb/tb_key_move_scheduler.sv - directed self-checking bench for key_move_scheduler
module tb_key_move_scheduler;
  logic       Clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_clk;
  logic [1:0] cmd_ready;
  logic [1:0] cmd_valid;
  logic [3:0] cmd_dir;
  logic [1:0] overflow;
  logic [7:0] missed_frames;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         cnt0, cnt1, gat0, ngrant;
  logic [1:0] gv0, gd0, gv1, gd1;
  logic       both;

  key_move_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .overflow(overflow), .missed_frames(missed_frames), .busy(busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0; keycode = 8'h00; frame_clk = 1'b0; cmd_ready = 2'b00;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] code);
    keycode = code;
    @(negedge Clk);
    keycode = 8'h00;
    @(negedge Clk);
  endtask

  // Raise frame_clk, watch a fixed window and record the first two grant events.
  task automatic run_frame(input int cycles);
    logic [1:0] prev;
    prev = 2'b00; cnt0 = 0; cnt1 = 0; gat0 = -1; ngrant = 0; both = 1'b0;
    gv0 = 2'b00; gd0 = 2'b00; gv1 = 2'b00; gd1 = 2'b00;
    frame_clk = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge Clk);
      if (i == 4) frame_clk = 1'b0;
      if (cmd_valid == 2'b11) both = 1'b1;
      if (cmd_valid[0]) cnt0++;
      if (cmd_valid[1]) cnt1++;
      if (cmd_valid != 2'b00 && cmd_valid != prev) begin
        if (ngrant == 0) begin
          gv0 = cmd_valid; gd0 = cmd_valid[1] ? cmd_dir[3:2] : cmd_dir[1:0]; gat0 = i;
        end else if (ngrant == 1) begin
          gv1 = cmd_valid; gd1 = cmd_valid[1] ? cmd_dir[3:2] : cmd_dir[1:0];
        end
        ngrant++;
      end
      prev = cmd_valid;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; keycode = 8'h00; frame_clk = 1'b0; cmd_ready = 2'b00;
    repeat (3) @(negedge Clk);
    n_checks++;
    if ({cmd_valid, cmd_dir, overflow, missed_frames, busy} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {cmd_valid, cmd_dir, overflow, missed_frames, busy});
    end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_single_grant();
    do_reset();
    cmd_ready = 2'b11;
    press(8'h1A);
    run_frame(12);
    n_checks++;
    if (gat0 !== 3) begin n_fail++; $display("FAIL t1_latency: got %0d required 3", gat0); end
    n_checks++;
    if (gv0 !== 2'b01 || gd0 !== 2'b00) begin
      n_fail++; $display("FAIL t1_grant: got valid %b dir %b required 01/00", gv0, gd0);
    end
    n_checks++;
    if (cnt0 !== 1 || cnt1 !== 0) begin
      n_fail++; $display("FAIL t1_counts: got p0 %0d p1 %0d required 1/0", cnt0, cnt1);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cmd_ready = 2'b11;
    press(8'h04);
    press(8'h4F);
    run_frame(12);
    n_checks++;
    if (gv0 !== 2'b01 || gd0 !== 2'b10 || gv1 !== 2'b10 || gd1 !== 2'b11 || both !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_frame1: got %b/%b %b/%b both %b required 01/10 10/11 both 0",
               gv0, gd0, gv1, gd1, both);
    end
    press(8'h16);
    press(8'h52);
    run_frame(12);
    n_checks++;
    if (gv0 !== 2'b10 || gd0 !== 2'b00 || gv1 !== 2'b01 || gd1 !== 2'b01) begin
      n_fail++;
      $display("FAIL t2_frame2_rotated: got %b/%b %b/%b required 10/00 01/01", gv0, gd0, gv1, gd1);
    end
    run_frame(12);
    n_checks++;
    if (cnt0 + cnt1 !== 0) begin
      n_fail++; $display("FAIL t2_frame3_empty: got %0d valid cycles required 0", cnt0 + cnt1);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h1A};
    do_reset();
    for (int k = 0; k < 5; k++) press(codes[k]);
    n_checks++;
    if (overflow !== 2'b01) begin
      n_fail++; $display("FAIL t3_overflow: got %b required 01", overflow);
    end
    cmd_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      run_frame(12);
      n_checks++;
      if (cnt0 !== 1 || gd0 !== k[1:0]) begin
        n_fail++;
        $display("FAIL t3_drain%0d: got cnt %0d dir %b required 1/%b", k, cnt0, gd0, k[1:0]);
      end
    end
    run_frame(12);
    n_checks++;
    if (cnt0 !== 0) begin n_fail++; $display("FAIL t3_drained: got %0d required 0", cnt0); end
  endtask

  task automatic test_timeout();
    do_reset();
    cmd_ready = 2'b01;
    press(8'h52);
    run_frame(300);
    n_checks++;
    if (cnt1 !== 255 || cnt0 !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_timeout: got p1 %0d p0 %0d busy %b required 255/0/0", cnt1, cnt0, busy);
    end
    cmd_ready = 2'b11;
    run_frame(12);
    n_checks++;
    if (gv0 !== 2'b10 || gd0 !== 2'b00 || gat0 !== 3 || cnt1 !== 1) begin
      n_fail++;
      $display("FAIL t4_retained: got %b/%b at %0d cnt %0d required 10/00 at 3 cnt 1",
               gv0, gd0, gat0, cnt1);
    end
  endtask

  task automatic test_back_to_back_ticks();
    logic seen;
    do_reset();
    press(8'h1A);
    press(8'h52);
    frame_clk = 1'b1; repeat (4) @(negedge Clk);
    frame_clk = 1'b0; repeat (4) @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      frame_clk = 1'b1; repeat (4) @(negedge Clk);
      frame_clk = 1'b0; repeat (4) @(negedge Clk);
    end
    n_checks++;
    if (missed_frames !== 8'd2 || busy !== 1'b1 || cmd_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL t5_missed: got %0d busy %b valid %b required 2/1/01",
               missed_frames, busy, cmd_valid);
    end
    cmd_ready = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (!busy) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL t5_idle_timeout: got busy 1 required 0"); end
    @(negedge Clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_pending: got busy %b required 1", busy); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (!busy) seen = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (busy) seen = 1'b0;
    end
    n_checks++;
    if (!seen || missed_frames !== 8'd2) begin
      n_fail++;
      $display("FAIL t5_settle: got idle %b missed %0d required 1/2", seen, missed_frames);
    end
    keycode = 8'h52;
    repeat (40) @(negedge Clk);
    keycode = 8'h00;
    @(negedge Clk);
    run_frame(12);
    n_checks++;
    if (cnt1 !== 1 || cnt0 !== 0) begin
      n_fail++; $display("FAIL t5_hold_one: got p1 %0d p0 %0d required 1/0", cnt1, cnt0);
    end
    run_frame(12);
    n_checks++;
    if (cnt1 !== 0) begin n_fail++; $display("FAIL t5_no_repeat: got %0d required 0", cnt1); end
  endtask

  task automatic test_async_reset();
    logic [7:0] codes [5] = '{8'h4F, 8'h52, 8'h51, 8'h50, 8'h4F};
    do_reset();
    press(8'h07);
    for (int k = 0; k < 5; k++) press(codes[k]);
    n_checks++;
    if (overflow !== 2'b10) begin n_fail++; $display("FAIL t6_overflow: got %b required 10", overflow); end
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (cmd_valid !== 2'b01 || cmd_dir[1:0] !== 2'b11) begin
      n_fail++; $display("FAIL t6_grant: got %b/%b required 01/11", cmd_valid, cmd_dir[1:0]);
    end
    #2 Reset = 1'b0;
    #1;
    n_checks++;
    if ({cmd_valid, cmd_dir, overflow, missed_frames, busy} !== 17'h0) begin
      n_fail++;
      $display("FAIL t6_async_clear: got %h required 0",
               {cmd_valid, cmd_dir, overflow, missed_frames, busy});
    end
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    cmd_ready = 2'b11;
    @(negedge Clk);
    run_frame(12);
    n_checks++;
    if (cnt0 + cnt1 !== 0) begin
      n_fail++; $display("FAIL t6_fifo_empty: got %0d valid cycles required 0", cnt0 + cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_back_to_back_ticks();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
